// File: rtl/gol_engine.sv
`default_nettype none
// ============================================================================
// Module      : gol_engine
// Description : Conway Game-of-Life evolution core for an 8x8 board.
//               Captures a seed board from the pattern loader, then evolves it
//               one generation per step pulse (IDLE) or once every TICK_DIV
//               clocks (RUN). Board, generation count and status flags are
//               all registered.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous reset, active-low
//               load         - capture pattern_mat into the board
//               pattern_mat  - seed board, row 0 = [63:56], col 0 = row MSB
//               run          - 1 = free-run, 0 = single-step
//               step         - advance one generation (IDLE only)
//               board        - current generation
//               gen_count    - generations since last load, saturating
//               gen_valid    - 1-cycle pulse after each evolution
//               stable       - last evolution left the board unchanged
//               extinct      - board is all zero
// Config      : define GOL_TORUS_WRAP_EN for toroidal edge wrapping;
//               default treats cells outside the board as dead.
// Revision    : 1.0 - initial release
// ============================================================================
module gol_engine #(
   parameter int TICK_DIV = 25_000_000,
   parameter int CNT_W    = 25,
   parameter int GEN_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [63:0]      pattern_mat,
   input  logic             run,
   input  logic             step,
   output logic [63:0]      board,
   output logic [GEN_W-1:0] gen_count,
   output logic             gen_valid,
   output logic             stable,
   output logic             extinct
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_presc;
   logic [63:0]      r_board;
   logic [GEN_W-1:0] r_gen;
   logic             r_gen_valid;
   logic             r_stable;
   logic             r_extinct;

   logic [63:0]      w_next;
   logic             w_tick;

   // Value of cell (r,c); coordinates may lie one step outside the board.
   function automatic logic f_cell(input logic [63:0] b, input int r, input int c);
      logic [5:0] v_idx;
`ifdef GOL_TORUS_WRAP_EN
      v_idx = 6'(63 - (8 * ((r + 8) % 8) + ((c + 8) % 8)));
      return b[v_idx];
`else
      if (r < 0 || r > 7 || c < 0 || c > 7) begin
         return 1'b0;
      end
      v_idx = 6'(63 - (8 * r + c));
      return b[v_idx];
`endif
   endfunction

   // One full generation of the life rule applied to every cell.
   function automatic logic [63:0] f_next(input logic [63:0] b);
      logic [63:0] v_out;
      logic [3:0]  v_cnt;
      logic        v_self;
      logic [5:0]  v_idx;
      v_out = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            v_cnt = 4'd0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     v_cnt = v_cnt + {3'b000, f_cell(b, r + dr, c + dc)};
                  end
               end
            end
            v_idx        = 6'(63 - (8 * r + c));
            v_self       = b[v_idx];
            v_out[v_idx] = (v_cnt == 4'd3) || (v_self && (v_cnt == 4'd2));
         end
      end
      return v_out;
   endfunction

   assign w_next = f_next(r_board);
   assign w_tick = (r_presc == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_presc     <= '0;
         r_board     <= '0;
         r_gen       <= '0;
         r_gen_valid <= 1'b0;
         r_stable    <= 1'b0;
         r_extinct   <= 1'b1;
      end else begin
         r_gen_valid <= 1'b0;
         if (load) begin
            // Load wins over everything and leaves the mode untouched.
            r_board   <= pattern_mat;
            r_gen     <= '0;
            r_stable  <= 1'b0;
            r_extinct <= (pattern_mat == 64'd0);
            r_presc   <= '0;
         end else if (r_state == S_IDLE && run) begin
            // Entering RUN swallows any simultaneous step.
            r_state <= S_RUN;
            r_presc <= '0;
         end else if (r_state == S_RUN && !run) begin
            r_state <= S_IDLE;
            r_presc <= '0;
         end else if ((r_state == S_IDLE && step) || (r_state == S_RUN && w_tick)) begin
            r_board     <= w_next;
            r_stable    <= (w_next == r_board);
            r_extinct   <= (w_next == 64'd0);
            r_gen_valid <= 1'b1;
            if (r_gen != '1) begin
               r_gen <= r_gen + GEN_W'(1);
            end
            r_presc <= '0;
         end else if (r_state == S_RUN) begin
            r_presc <= r_presc + CNT_W'(1);
         end
      end
   end

   assign board     = r_board;
   assign gen_count = r_gen;
   assign gen_valid = r_gen_valid;
   assign stable    = r_stable;
   assign extinct   = r_extinct;

endmodule
`default_nettype wire

// File: tb/tb_gol_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_gol_engine
// Description : Self-checking bench for gol_engine (TICK_DIV=4, GEN_W=4).
//               Expected boards come from a grid-based life model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_engine;

   localparam int TD  = 4;
   localparam int GW  = 4;
   localparam int GMAX = (1 << GW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic [63:0]   pattern_mat = 64'd0;
   logic          run = 1'b0;
   logic          step = 1'b0;
   logic [63:0]   board;
   logic [GW-1:0] gen_count;
   logic          gen_valid;
   logic          stable;
   logic          extinct;

   int checks = 0;
   int errors = 0;

   logic [63:0] m_board;
   int          m_gen;
   logic        m_stable;
   logic        m_extinct;

   gol_engine #(.TICK_DIV(TD), .CNT_W(3), .GEN_W(GW)) dut (
      .clk(clk), .rst(rst), .load(load), .pattern_mat(pattern_mat),
      .run(run), .step(step), .board(board), .gen_count(gen_count),
      .gen_valid(gen_valid), .stable(stable), .extinct(extinct)
   );

   always #5 clk = ~clk;

   // Life rule on an 8x8 grid of cells.
   function automatic logic [63:0] life(input logic [63:0] b);
      bit          g[8][8];
      logic [63:0] n;
      int          cnt, rr, cc;
      n = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            g[r][c] = b[63 - (8 * r + c)];
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr == 0 && dc == 0) continue;
                  rr = r + dr;
                  cc = c + dc;
`ifdef GOL_TORUS_WRAP_EN
                  cnt += int'(g[(rr + 8) % 8][(cc + 8) % 8]);
`else
                  if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) cnt += int'(g[rr][cc]);
`endif
               end
            end
            n[63 - (8 * r + c)] = g[r][c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
         end
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_load(input logic [63:0] p);
      m_board = p; m_gen = 0; m_stable = 1'b0; m_extinct = (p == 64'd0);
   endtask

   task automatic model_evolve();
      logic [63:0] n;
      n = life(m_board);
      m_stable  = (n == m_board);
      m_extinct = (n == 64'd0);
      m_board   = n;
      if (m_gen < GMAX) m_gen++;
   endtask

   task automatic check_all(input string tag, input logic gv);
      chk({tag, ".board"},   board, m_board);
      chk({tag, ".gen"},     {60'd0, gen_count}, 64'(m_gen));
      chk({tag, ".stable"},  {63'd0, stable}, {63'd0, m_stable});
      chk({tag, ".extinct"}, {63'd0, extinct}, {63'd0, m_extinct});
      chk({tag, ".valid"},   {63'd0, gen_valid}, {63'd0, gv});
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_load(input logic [63:0] p);
      pattern_mat = p; load = 1'b1; cyc(); load = 1'b0;
      model_load(p);
   endtask

   task automatic do_step();
      step = 1'b1; cyc(); step = 1'b0;
      model_evolve();
   endtask

   initial begin
      logic [63:0] p;
      // Reset
      #2 rst = 1'b0; #1;
      model_load(64'd0);
      check_all("reset", 1'b0);
      cyc(); cyc(); rst = 1'b1; cyc();

      // Blinker
      do_load(64'hE000_0000_0000_0000);
      check_all("blk_load", 1'b0);
      do_step();
`ifdef GOL_TORUS_WRAP_EN
      chk("blk_dir", board, 64'h4040_0000_0000_0040);
`else
      chk("blk_dir", board, 64'h4040_0000_0000_0000);
`endif
      check_all("blk_s1", 1'b1);
      cyc();
      check_all("blk_hold", 1'b0);
      do_step();
      check_all("blk_s2", 1'b1);

      // Block still life
      do_load(64'hC0C0_0000_0000_0000);
      do_step();
      chk("block_dir", board, 64'hC0C0_0000_0000_0000);
      check_all("block", 1'b1);

      // Held load re-captures each cycle
      pattern_mat = 64'h1234_5678_9ABC_DEF0; load = 1'b1; step = 1'b1; cyc();
      pattern_mat = 64'h0F0F_0000_00F0_F000; cyc(); load = 1'b0; step = 1'b0;
      model_load(64'h0F0F_0000_00F0_F000);
      check_all("held_load", 1'b0);

      // RUN timing, step ignored while running
      do_load(64'h8000_0000_0000_0000);
      run = 1'b1; step = 1'b1; cyc();
      check_all("run_entry", 1'b0);
      for (int k = 1; k <= 3 * TD; k++) begin
         cyc();
         if (k % TD == 0) begin
            model_evolve();
            check_all("run_tick", 1'b1);
         end else begin
            check_all("run_wait", 1'b0);
         end
      end
      step = 1'b0;
      chk("run_gen3", {60'd0, gen_count}, 64'd3);

      // Load mid-RUN restarts prescaler
      do_load(64'h4020_E000_0000_0000);
      check_all("midrun_load", 1'b0);
      for (int k = 1; k <= TD; k++) begin
         cyc();
         if (k == TD) begin
            model_evolve();
            check_all("midrun_tick", 1'b1);
         end else begin
            check_all("midrun_wait", 1'b0);
         end
      end
      run = 1'b0; cyc();
      check_all("run_exit", 1'b0);

      // run+step together in IDLE: enter RUN, step dropped
      step = 1'b1; run = 1'b1; cyc(); step = 1'b0;
      check_all("run_step_drop", 1'b0);
      run = 1'b0; cyc();
      check_all("run_step_exit", 1'b0);

      // Random boards in single-step mode
      for (int t = 0; t < 6; t++) begin
         p = {$urandom, $urandom};
         do_load(p);
         for (int s = 0; s < 4; s++) begin
            do_step();
            check_all("rand", 1'b1);
         end
      end

      // Generation counter saturation
      do_load(64'hC0C0_0000_0000_0000);
      for (int s = 0; s < GMAX + 3; s++) do_step();
      check_all("gen_sat", 1'b1);

      // Reset mid-RUN is immediate
      do_load({$urandom, $urandom});
      run = 1'b1; cyc(); cyc();
      rst = 1'b0; #1;
      model_load(64'd0);
      check_all("reset_run", 1'b0);
      run = 1'b0; cyc(); rst = 1'b1; cyc();
      check_all("reset_after", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
